// File: rtl/voxel_pkg.sv
// Shared defaults, voxel address/mask types and FSM states for the cylindrical voxel writer.
package voxel_pkg;

   localparam int DEF_SLICE_BITS  = 6;
   localparam int DEF_RADIUS_BITS = 5;
   localparam int DEF_Z_BITS      = 5;
   localparam int DEF_ADDR_W      = DEF_SLICE_BITS + DEF_RADIUS_BITS;
   localparam int DEF_WORD_W      = 2**DEF_Z_BITS;

   typedef logic [DEF_ADDR_W-1:0] voxel_addr_t;
   typedef logic [DEF_WORD_W-1:0] voxel_mask_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } writer_state_t;

endpackage

// File: rtl/point_fifo.sv
// point_fifo: synchronous FIFO holding quantized points ahead of the read-modify-write pipeline.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none upstream; a push while full is refused unless a pop frees the slot that same cycle.
module point_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic             push_ok
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign push_ok = push && (!full || do_pop);
   assign head    = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/cylindrical_voxel_writer.sv
// cylindrical_voxel_writer: quantizes converter points to voxels and ORs their z bit into the frame buffer; VOXEL_WRITER_COUNT_EN adds point_count.
// Latency: data_ready in N -> mem_rd_en in N+1 -> mem_wr_en in N+1+RAM_LATENCY; clear sweep takes one cycle per word.
// Backpressure: none upstream; points queue in a FIFO while busy and are dropped (sticky overflow) when it is full.
module cylindrical_voxel_writer
   import voxel_pkg::*;
#(
   parameter int SLICE_BITS  = DEF_SLICE_BITS,
   parameter int RADIUS_BITS = DEF_RADIUS_BITS,
   parameter int Z_BITS      = DEF_Z_BITS,
   parameter int RAM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [7:0]                        theta,
   input  logic [7:0]                        radius,
   input  logic [7:0]                        z,
   input  logic                              data_ready,
   input  logic                              clear_in,
   output logic                              busy,
   output logic                              overflow,
   output logic                              mem_rd_en,
   output logic [SLICE_BITS+RADIUS_BITS-1:0] mem_rd_addr,
   input  logic [2**Z_BITS-1:0]              mem_rd_data,
   output logic                              mem_wr_en,
   output logic [SLICE_BITS+RADIUS_BITS-1:0] mem_wr_addr,
   output logic [2**Z_BITS-1:0]              mem_wr_data
`ifdef VOXEL_WRITER_COUNT_EN
   ,
   output logic [15:0]                       point_count
`endif
);

   localparam int AW = SLICE_BITS + RADIUS_BITS;
   localparam int WW = 2**Z_BITS;
   localparam int EW = AW + WW;
   localparam logic [AW-1:0]          LAST_ADDR  = '1;
   localparam logic [RAM_LATENCY-1:0] LAST_STAGE = RAM_LATENCY'(1) << (RAM_LATENCY-1);

   writer_state_t state, state_nxt;

   logic [AW-1:0] clr_addr;
   logic          clr_pend;
   logic          clr_start;
   logic          clear_req;

   logic [AW-1:0] in_addr;
   logic [WW-1:0] in_mask;
   logic [EW-1:0] fifo_head;
   logic [AW-1:0] head_addr;
   logic [WW-1:0] head_mask;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push_ok;

   logic          issue;
   logic          hazard;
   logic          drained;
   logic          retire;

   logic [RAM_LATENCY-1:0] pipe_vld;
   logic [AW-1:0]          pipe_addr [RAM_LATENCY];
   logic [WW-1:0]          pipe_mask [RAM_LATENCY];

   logic unused_lsbs;
   assign unused_lsbs = ^{theta, radius, z, fifo_full};

   always_comb begin
      in_addr = {theta[7 -: SLICE_BITS], radius[7 -: RADIUS_BITS]};
      in_mask = WW'(1) << z[7 -: Z_BITS];
   end

   point_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (data_ready),
      .push_data ({in_addr, in_mask}),
      .pop       (issue),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .push_ok   (push_ok)
   );

   assign head_addr = fifo_head[EW-1 -: AW];
   assign head_mask = fifo_head[WW-1:0];

   // The retiring stage counts as in flight: its write lands at this edge, so the
   // matching head may only read one cycle later.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
         if (pipe_vld[i] && (pipe_addr[i] == head_addr)) hazard = 1'b1;
      end
   end

   assign retire    = pipe_vld[RAM_LATENCY-1];
   assign drained   = ((pipe_vld & ~LAST_STAGE) == '0);
   assign clear_req = clear_in || clr_pend;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         CLEAR: begin
            if (!clear_in && (clr_addr == LAST_ADDR)) state_nxt = IDLE;
         end
         IDLE, RUN: begin
            if (clear_req) begin
               if (drained) state_nxt = CLEAR;
            end else begin
               issue = !fifo_empty && !hazard;
               if (!fifo_empty)          state_nxt = RUN;
               else if (pipe_vld == '0)  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clr_start = (state_nxt == CLEAR) && ((state != CLEAR) || clear_in);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= CLEAR;
         clr_addr <= '0;
         clr_pend <= 1'b0;
         overflow <= 1'b0;
         pipe_vld <= '0;
      end else begin
         state <= state_nxt;

         if (clr_start)          clr_addr <= '0;
         else if (state == CLEAR) clr_addr <= clr_addr + AW'(1);

         if (clr_start)     clr_pend <= 1'b0;
         else if (clear_in) clr_pend <= 1'b1;

         if (clear_in)                    overflow <= 1'b0;
         else if (data_ready && !push_ok) overflow <= 1'b1;

         pipe_vld[0] <= issue;
         for (int i = 1; i < RAM_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   always_ff @(posedge clk_in) begin
      pipe_addr[0] <= head_addr;
      pipe_mask[0] <= head_mask;
      for (int i = 1; i < RAM_LATENCY; i++) begin
         pipe_addr[i] <= pipe_addr[i-1];
         pipe_mask[i] <= pipe_mask[i-1];
      end
   end

   // The FSM resets into CLEAR, so outputs are held quiet while rst_in is high.
   always_comb begin
      busy        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      if (!rst_in) begin
         busy = (state == CLEAR) || !fifo_empty || (pipe_vld != '0) || clr_pend;
         if (state == CLEAR) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = clr_addr;
         end else if (retire) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = pipe_addr[RAM_LATENCY-1];
            mem_wr_data = mem_rd_data | pipe_mask[RAM_LATENCY-1];
         end
         if (issue) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = head_addr;
         end
      end
   end

`ifdef VOXEL_WRITER_COUNT_EN
   always_ff @(posedge clk_in) begin
      if (rst_in || clr_start)                 point_count <= '0;
      else if (retire && (point_count != '1))  point_count <= point_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_cylindrical_voxel_writer.sv
// Self-checking bench for cylindrical_voxel_writer: frame-buffer RAM model plus a voxel-level reference of expected writes.
module tb_cylindrical_voxel_writer;

   localparam int SB  = 6;
   localparam int RB  = 5;
   localparam int ZB  = 5;
   localparam int AW  = SB + RB;
   localparam int NW  = 2**AW;
   localparam int LAT = 2;

   typedef struct {
      int          cyc;
      int          addr;
      logic [31:0] data;
   } ev_t;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic [7:0]    theta, radius, z;
   logic          data_ready, clear_in;
   logic          busy, overflow;
   logic          mem_rd_en, mem_wr_en;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;
   logic [31:0]   mem_rd_data, mem_wr_data;
`ifdef VOXEL_WRITER_COUNT_EN
   logic [15:0]   point_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] ram [NW];
   logic [31:0] rd_pipe;
   logic [31:0] exp_ram [NW];
   ev_t         wr_q[$];
   ev_t         rd_q[$];
   ev_t         exp_wr[$];

   cylindrical_voxel_writer #(
      .SLICE_BITS (SB), .RADIUS_BITS (RB), .Z_BITS (ZB), .RAM_LATENCY (LAT), .FIFO_DEPTH (8)
   ) dut (
      .clk_in (clk_in), .rst_in (rst_in),
      .theta (theta), .radius (radius), .z (z),
      .data_ready (data_ready), .clear_in (clear_in),
      .busy (busy), .overflow (overflow),
      .mem_rd_en (mem_rd_en), .mem_rd_addr (mem_rd_addr), .mem_rd_data (mem_rd_data),
      .mem_wr_en (mem_wr_en), .mem_wr_addr (mem_wr_addr), .mem_wr_data (mem_wr_data)
`ifdef VOXEL_WRITER_COUNT_EN
      , .point_count (point_count)
`endif
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Simple-dual-port RAM, read-first, data valid RAM_LATENCY cycles after mem_rd_en.
   always @(posedge clk_in) begin
      if (mem_wr_en === 1'b1) ram[mem_wr_addr] <= mem_wr_data;
      rd_pipe     <= (mem_rd_en === 1'b1) ? ram[mem_rd_addr] : 32'h0;
      mem_rd_data <= rd_pipe;
   end

   always @(negedge clk_in) begin
      if (mem_wr_en === 1'b1) wr_q.push_back('{cyc, int'(mem_wr_addr), mem_wr_data});
      if (mem_rd_en === 1'b1) rd_q.push_back('{cyc, int'(mem_rd_addr), 32'h0});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int q_addr(input logic [7:0] t, input logic [7:0] r);
      return ((int'(t) >> (8 - SB)) << RB) + (int'(r) >> (8 - RB));
   endfunction

   function automatic logic [31:0] q_mask(input logic [7:0] zz);
      return 32'h1 << (int'(zz) >> (8 - ZB));
   endfunction

   function automatic ev_t wr_at(input int i);
      ev_t e;
      e = '{-1, -1, 'x};
      if (i < wr_q.size()) e = wr_q[i];
      return e;
   endfunction

   function automatic ev_t rd_at(input int i);
      ev_t e;
      e = '{-1, -1, 'x};
      if (i < rd_q.size()) e = rd_q[i];
      return e;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NW; i++) begin
         exp_ram[i] = 32'h0;
         exp_wr.push_back('{-1, i, 32'h0});
      end
   endtask

   task automatic model_point(input logic [7:0] t, input logic [7:0] r, input logic [7:0] zz);
      int a;
      a = q_addr(t, r);
      exp_ram[a] = exp_ram[a] | q_mask(zz);
      exp_wr.push_back('{-1, a, exp_ram[a]});
   endtask

   task automatic push_pt(input logic [7:0] t, input logic [7:0] r, input logic [7:0] zz, output int c);
      @(posedge clk_in); #1;
      theta = t; radius = r; z = zz; data_ready = 1'b1;
      c = cyc;
   endtask

   task automatic drive_idle();
      @(posedge clk_in); #1;
      data_ready = 1'b0; clear_in = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while ((busy !== 1'b0) && (n < 4000));
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic compare_writes(input string tag, input int wb);
      int bad;
      ev_t e;
      bad = 0;
      check({tag, "_wr_count"}, wr_q.size() - wb, exp_wr.size());
      foreach (exp_wr[i]) begin
         e = wr_at(wb + i);
         if ((e.addr !== exp_wr[i].addr) || (e.data !== exp_wr[i].data)) bad++;
      end
      check({tag, "_wr_seq_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < NW; i++) if (ram[i] !== exp_ram[i]) bad++;
      check({tag, "_ram_bad"}, bad, 0);
      exp_wr.delete();
   endtask

   initial begin
      int   n0, rel, wb, rb, c;
      logic [7:0] t, r, zz;
      logic [7:0] pts [9][3];

      rst_in = 1'b1; theta = '0; radius = '0; z = '0; data_ready = 1'b0; clear_in = 1'b0;

      // Reset values
      repeat (3) @(negedge clk_in);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_rd_en", mem_rd_en, 1'b0);
      check("rst_wr_en", mem_wr_en, 1'b0);
      check("rst_rd_addr", mem_rd_addr, '0);
      check("rst_wr_addr", mem_wr_addr, '0);
      check("rst_wr_data", mem_wr_data, '0);

      // Post-reset sweep
      @(posedge clk_in); #1;
      rst_in = 1'b0; rel = cyc;
      model_clear();
      @(negedge clk_in);
      check("busy_after_rst", busy, 1'b1);
      wait_idle("sweep0");
      check("sweep0_first_cyc", wr_at(0).cyc, rel);
      check("sweep0_last_cyc", wr_at(NW - 1).cyc, rel + NW - 1);
      compare_writes("sweep0", 0);

      // Single point
      wb = wr_q.size(); rb = rd_q.size();
      push_pt(8'h80, 8'h40, 8'h10, n0);
      drive_idle();
      model_point(8'h80, 8'h40, 8'h10);
      wait_idle("single");
      check("single_rd_addr", rd_at(rb).addr, 1032);
      check("single_rd_cyc", rd_at(rb).cyc, n0 + 1);
      check("single_wr_addr", wr_at(wb).addr, 1032);
      check("single_wr_cyc", wr_at(wb).cyc, n0 + 1 + LAT);
      check("single_wr_data", wr_at(wb).data, 32'h4);
      compare_writes("single", wb);

      // Back-to-back same voxel column: read-modify-write merge with hazard stall
      wb = wr_q.size(); rb = rd_q.size();
      push_pt(8'h80, 8'h40, 8'h10, n0);
      push_pt(8'h80, 8'h40, 8'h18, c);
      drive_idle();
      model_point(8'h80, 8'h40, 8'h10);
      model_point(8'h80, 8'h40, 8'h18);
      wait_idle("merge");
      check("merge_rd2_cyc", rd_at(rb + 1).cyc, n0 + 2 + LAT);
      check("merge_wr1_cyc", wr_at(wb).cyc, n0 + 1 + LAT);
      check("merge_wr2_cyc", wr_at(wb + 1).cyc, n0 + 2 + 2 * LAT);
      check("merge_wr2_data", wr_at(wb + 1).data, 32'hC);
      compare_writes("merge", wb);

      // Throughput: distinct columns in consecutive cycles
      wb = wr_q.size(); rb = rd_q.size();
      t = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin
         r  = 8'(i * 8 + int'($urandom_range(0, 7)));
         zz = 8'($urandom_range(0, 255));
         push_pt(t, r, zz, c);
         if (i == 0) n0 = c;
         model_point(t, r, zz);
      end
      drive_idle();
      wait_idle("thru");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("thru_rd%0d_cyc", i), rd_at(rb + i).cyc, n0 + 1 + i);
         check($sformatf("thru_wr%0d_cyc", i), wr_at(wb + i).cyc, n0 + 1 + LAT + i);
      end
      compare_writes("thru", wb);

      // Random points over a few columns with random gaps: hazards and merges
      wb = wr_q.size(); rb = rd_q.size();
      for (int i = 0; i < 24; i++) begin
         t  = ($urandom_range(0, 1) == 0) ? 8'h13 : 8'hC7;
         r  = ($urandom_range(0, 1) == 0) ? 8'h2A : 8'hF1;
         zz = 8'($urandom_range(0, 255));
         push_pt(t, r, zz, c);
         model_point(t, r, zz);
         if ($urandom_range(0, 2) == 0) drive_idle();
      end
      drive_idle();
      wait_idle("rand");
      check("rand_rd_count", rd_q.size() - rb, 24);
      compare_writes("rand", wb);

      // Overflow: nine points during a clear sweep
      wb = wr_q.size();
      @(posedge clk_in); #1; clear_in = 1'b1;
      model_clear();
      for (int i = 0; i < 9; i++) begin
         pts[i][0] = 8'($urandom_range(0, 255));
         pts[i][1] = 8'($urandom_range(0, 255));
         pts[i][2] = 8'($urandom_range(0, 255));
         push_pt(pts[i][0], pts[i][1], pts[i][2], c);
         clear_in = 1'b0;
         if (i < 8) model_point(pts[i][0], pts[i][1], pts[i][2]);
      end
      drive_idle();
      @(negedge clk_in);
      check("ovf_set", overflow, 1'b1);
      wait_idle("ovf");
      compare_writes("ovf", wb);
      check("ovf_sticky", overflow, 1'b1);
      wb = wr_q.size();
      @(posedge clk_in); #1; clear_in = 1'b1;
      model_clear();
      drive_idle();
      @(negedge clk_in);
      check("ovf_cleared", overflow, 1'b0);
      wait_idle("ovf_clr");
      compare_writes("ovf_clr", wb);

      // Clear arriving while points are in flight; a point lands in the clear cycle too
      wb = wr_q.size();
      t = 8'($urandom_range(0, 255));
      for (int i = 0; i < 6; i++) begin
         r  = 8'((i + 8) * 8);
         zz = 8'($urandom_range(0, 255));
         pts[i][0] = t; pts[i][1] = r; pts[i][2] = zz;
         push_pt(t, r, zz, c);
         if (i == 0) n0 = c;
         clear_in = (i == 3);
      end
      drive_idle();
      model_point(pts[0][0], pts[0][1], pts[0][2]);
      model_point(pts[1][0], pts[1][1], pts[1][2]);
      model_clear();
      for (int i = 2; i < 6; i++) model_point(pts[i][0], pts[i][1], pts[i][2]);
      wait_idle("midclr");
      check("midclr_wr1_cyc", wr_at(wb).cyc, n0 + 1 + LAT);
      check("midclr_wr2_cyc", wr_at(wb + 1).cyc, n0 + 2 + LAT);
      check("midclr_sweep_cyc", wr_at(wb + 2).cyc, n0 + 3 + LAT);
      check("midclr_sweep_addr", wr_at(wb + 2).addr, 0);
      compare_writes("midclr", wb);

      // Reset mid-operation: queued and in-flight points are abandoned
      for (int i = 0; i < 3; i++) begin
         push_pt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), c);
      end
      @(posedge clk_in); #1;
      data_ready = 1'b0; rst_in = 1'b1;
      @(negedge clk_in);
      check("midrst_busy", busy, 1'b0);
      check("midrst_wr_en", mem_wr_en, 1'b0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      wb = wr_q.size();
      model_clear();
      wait_idle("midrst");
      check("midrst_overflow", overflow, 1'b0);
      compare_writes("midrst", wb);

`ifdef VOXEL_WRITER_COUNT_EN
      check("cnt_after_rst", point_count, 16'd0);
      wb = wr_q.size();
      for (int i = 0; i < 5; i++) begin
         t = 8'(i * 32 + 5);
         zz = 8'($urandom_range(0, 255));
         push_pt(t, 8'h77, zz, c);
         model_point(t, 8'h77, zz);
      end
      drive_idle();
      wait_idle("cnt");
      check("cnt_five", point_count, 16'd5);
      compare_writes("cnt", wb);
      @(posedge clk_in); #1; clear_in = 1'b1;
      drive_idle();
      @(negedge clk_in);
      check("cnt_cleared", point_count, 16'd0);
      wait_idle("cnt_clr");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
